// File: rtl/switch_debounce.sv
// Switch debouncer for a 16-bit DIP-switch bank.
// Each raw pin goes through a two-flop synchronizer. A shared prescaler
// produces a sample tick every TICK_DIV cycles. On each tick, a per-bit
// counter measures how many consecutive samples disagree with the
// published level. After STABLE_TICKS disagreeing ticks the bit flips.
// When deben is low the synchronized level passes straight through.
// Every change to switch_o is reported with a one-cycle chg_pulse and a
// mask of the bits that changed on that edge.
module switch_debounce #(
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 4
) (
    input  logic        debclk,
    input  logic        debrst,
    input  logic [15:0] switch_raw,
    input  logic        deben,
    output logic [15:0] switch_o,
    output logic        chg_pulse,
    output logic [15:0] chg_mask
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]    CNT_LAST = 4'(STABLE_TICKS - 1);

    logic [15:0]   s1;
    logic [15:0]   s2;
    logic [PW-1:0] pre;
    logic          tick;
    logic [3:0]    cnt      [16];
    logic [3:0]    cnt_next [16];
    logic [15:0]   sw_next;
    logic [15:0]   diff;

    // Two-flop synchronizer for the asynchronous switch pins
    always_ff @(posedge debclk or negedge debrst) begin
        if (!debrst) begin
            s1 <= 16'h0000;
            s2 <= 16'h0000;
        end else begin
            s1 <= switch_raw;
            s2 <= s1;
        end
    end

    // Sample prescaler: free-running while debouncing, parked at 0 in bypass
    always_ff @(posedge debclk or negedge debrst) begin
        if (!debrst) begin
            pre <= '0;
        end else if (!deben) begin
            pre <= '0;
        end else if (pre == PRE_LAST) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    assign tick = deben && (pre == PRE_LAST);

    // Per-bit qualification: count disagreeing ticks, accept on the last one
    always_comb begin
        sw_next = switch_o;
        for (int i = 0; i < 16; i++) begin
            cnt_next[i] = cnt[i];
        end
        if (!deben) begin
            sw_next = s2;
            for (int i = 0; i < 16; i++) begin
                cnt_next[i] = 4'd0;
            end
        end else if (tick) begin
            for (int i = 0; i < 16; i++) begin
                if (s2[i] == switch_o[i]) begin
                    cnt_next[i] = 4'd0;
                end else if (cnt[i] == CNT_LAST) begin
                    sw_next[i]  = s2[i];
                    cnt_next[i] = 4'd0;
                end else begin
                    cnt_next[i] = cnt[i] + 4'd1;
                end
            end
        end
    end

    assign diff = switch_o ^ sw_next;

    // Qualification counters
    always_ff @(posedge debclk or negedge debrst) begin
        if (!debrst) begin
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Published level plus change report registered on the same edge
    always_ff @(posedge debclk or negedge debrst) begin
        if (!debrst) begin
            switch_o  <= 16'h0000;
            chg_mask  <= 16'h0000;
            chg_pulse <= 1'b0;
        end else begin
            switch_o  <= sw_next;
            chg_mask  <= diff;
            chg_pulse <= |diff;
        end
    end

endmodule
